// File: rtl/pc_sequencer_pkg.sv
// Shared encodings and widths for the program-counter sequencer.
package pc_sequencer_pkg;

  localparam int PC_W    = 9;
  localparam int FLAGS_W = 4;

  // Flag bit positions inside the flags register
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [2:0] {
    OP_NEXT = 3'b000,
    OP_JMP  = 3'b001,
    OP_JIF  = 3'b010,
    OP_JNIF = 3'b011,
    OP_CALL = 3'b100,
    OP_RET  = 3'b101,
    OP_HALT = 3'b110,
    OP_RETI = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_HALT  = 2'b01,
    ST_FAULT = 2'b10
  } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus between the sequencer and the downstream return stack.
interface pc_sequencer_if;
  import pc_sequencer_pkg::*;

  logic               stack_push_en;
  logic               stack_pop_en;
  logic [PC_W-1:0]    stack_pc;
  logic [FLAGS_W-1:0] stack_flags;
  logic [PC_W-1:0]    stack_top_pc;
  logic [FLAGS_W-1:0] stack_top_flags;

  modport master (
    output stack_push_en, stack_pop_en, stack_pc, stack_flags,
    input  stack_top_pc, stack_top_flags
  );

  modport slave (
    input  stack_push_en, stack_pop_en, stack_pc, stack_flags,
    output stack_top_pc, stack_top_flags
  );
endinterface

// File: rtl/pc_sequencer_next_logic.sv
// Combinational next-PC selection and stack strobe decode.
module pc_next_logic
  import pc_sequencer_pkg::*;
#(
  parameter int              STACK_DEPTH = 5,
  parameter logic [PC_W-1:0] IRQ_VECTOR  = 9'h1F0
) (
  input  state_e             state,
  input  logic               en,
  input  logic [2:0]         op,
  input  logic [1:0]         cond,
  input  logic [PC_W-1:0]    target,
  input  logic [PC_W-1:0]    pc,
  input  logic [FLAGS_W-1:0] flags,
  input  logic [2:0]         depth,
  input  logic               in_isr,
  input  logic               irq,
  input  logic [PC_W-1:0]    stack_top_pc,
  output logic               take_irq,
  output logic               push_en,
  output logic               pop_en,
  output logic [PC_W-1:0]    stack_pc,
  output logic [PC_W-1:0]    pc_nxt,
  output logic               go_halt,
  output logic               go_fault,
  output logic               do_reti
);

  localparam logic [2:0] DEPTH_MAX = 3'(STACK_DEPTH);

  logic [PC_W-1:0] seq_pc;
  logic            stack_full;
  logic            stack_empty;

  assign seq_pc      = pc + 9'd1;
  assign stack_full  = (depth == DEPTH_MAX);
  assign stack_empty = (depth == 3'd0);

  // Interrupt has priority over the presented op; otherwise decode op in RUN
  always_comb begin
    take_irq = 1'b0;
    push_en  = 1'b0;
    pop_en   = 1'b0;
    stack_pc = pc;
    pc_nxt   = pc;
    go_halt  = 1'b0;
    go_fault = 1'b0;
    do_reti  = 1'b0;

    if (irq && !in_isr && !stack_full && (state != ST_FAULT)) begin
      // Return address is pc-1 because the stack adds one on store,
      // bringing the return back onto the op that was discarded here.
      take_irq = 1'b1;
      push_en  = 1'b1;
      stack_pc = pc - 9'd1;
      pc_nxt   = IRQ_VECTOR;
    end else if ((state == ST_RUN) && en) begin
      unique case (op)
        OP_NEXT: pc_nxt = seq_pc;
        OP_JMP:  pc_nxt = target;
        OP_JIF:  pc_nxt = flags[cond] ? target : seq_pc;
        OP_JNIF: pc_nxt = flags[cond] ? seq_pc : target;
        OP_CALL: begin
          if (stack_full) begin
            go_fault = 1'b1;
          end else begin
            push_en = 1'b1;
            pc_nxt  = target;
          end
        end
        OP_RET, OP_RETI: begin
          if (stack_empty) begin
            go_fault = 1'b1;
          end else begin
            pop_en  = 1'b1;
            pc_nxt  = stack_top_pc;
            do_reti = (op == OP_RETI);
          end
        end
        OP_HALT: go_halt = 1'b1;
        default: pc_nxt = pc;
      endcase
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter, flags, stack depth tracking and RUN/HALT/FAULT control.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              STACK_DEPTH = 5,
  parameter logic [PC_W-1:0] IRQ_VECTOR  = 9'h1F0,
  parameter logic [PC_W-1:0] RESET_PC    = 9'h000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [2:0]          op,
  input  logic [1:0]          cond,
  input  logic [PC_W-1:0]     target,
  input  logic [FLAGS_W-1:0]  alu_flags,
  input  logic                flags_we,
  input  logic                irq,
  output logic                irq_ack,
  output logic [PC_W-1:0]     pc,
  output logic [FLAGS_W-1:0]  flags,
  pc_sequencer_if.master      stack,
  output logic [2:0]          depth,
  output logic                in_isr,
  output logic                halted,
  output logic                fault
);

  state_e             state_q;
  state_e             state_d;
  logic [PC_W-1:0]    pc_q;
  logic [FLAGS_W-1:0] flags_q;
  logic [2:0]         depth_q;
  logic               in_isr_q;

  logic               take_irq;
  logic               push_en;
  logic               pop_en;
  logic [PC_W-1:0]    stack_pc;
  logic [PC_W-1:0]    pc_nxt;
  logic               go_halt;
  logic               go_fault;
  logic               do_reti;

  pc_next_logic #(
    .STACK_DEPTH (STACK_DEPTH),
    .IRQ_VECTOR  (IRQ_VECTOR)
  ) u_next (
    .state        (state_q),
    .en           (en),
    .op           (op),
    .cond         (cond),
    .target       (target),
    .pc           (pc_q),
    .flags        (flags_q),
    .depth        (depth_q),
    .in_isr       (in_isr_q),
    .irq          (irq),
    .stack_top_pc (stack.stack_top_pc),
    .take_irq     (take_irq),
    .push_en      (push_en),
    .pop_en       (pop_en),
    .stack_pc     (stack_pc),
    .pc_nxt       (pc_nxt),
    .go_halt      (go_halt),
    .go_fault     (go_fault),
    .do_reti      (do_reti)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Next state: a taken interrupt always lands in RUN; FAULT is sticky
  always_comb begin
    state_d = state_q;
    if (take_irq)      state_d = ST_RUN;
    else if (go_fault) state_d = ST_FAULT;
    else if (go_halt)  state_d = ST_HALT;
  end

  // PC, flags, depth and ISR flag; RETI flag restore beats flags_we
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      flags_q  <= '0;
      depth_q  <= '0;
      in_isr_q <= 1'b0;
    end else begin
      pc_q <= pc_nxt;
      if (do_reti)
        flags_q <= stack.stack_top_flags;
      else if (flags_we && (state_q != ST_FAULT))
        flags_q <= alu_flags;
      if (push_en)     depth_q <= depth_q + 3'd1;
      else if (pop_en) depth_q <= depth_q - 3'd1;
      if (take_irq)     in_isr_q <= 1'b1;
      else if (do_reti) in_isr_q <= 1'b0;
    end
  end

  assign stack.stack_push_en = push_en;
  assign stack.stack_pop_en  = pop_en;
  assign stack.stack_pc      = stack_pc;
  assign stack.stack_flags   = flags_q;

  assign irq_ack = take_irq;
  assign pc      = pc_q;
  assign flags   = flags_q;
  assign depth   = depth_q;
  assign in_isr  = in_isr_q;
  assign halted  = (state_q == ST_HALT);
  assign fault   = (state_q == ST_FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench: emulates the return stack and predicts the sequencer
// with a queue-based behavioural model driven by directed and random ops.
module tb_pc_sequencer;

  localparam int M_RUN = 0, M_HALT = 1, M_FAULT = 2;
  localparam int VEC = 'h1F0;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] op;
  logic [1:0] cond;
  logic [8:0] target;
  logic [3:0] alu_flags;
  logic       flags_we;
  logic       irq;
  logic       irq_ack;
  logic [8:0] pc;
  logic [3:0] flags;
  logic [2:0] depth;
  logic       in_isr;
  logic       halted;
  logic       fault;

  pc_sequencer_if sif();

  pc_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .op        (op),
    .cond      (cond),
    .target    (target),
    .alu_flags (alu_flags),
    .flags_we  (flags_we),
    .irq       (irq),
    .irq_ack   (irq_ack),
    .pc        (pc),
    .flags     (flags),
    .stack     (sif),
    .depth     (depth),
    .in_isr    (in_isr),
    .halted    (halted),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Return-stack emulation: stores stack_pc+1 and flags
  logic [8:0] env_pc [8];
  logic [3:0] env_fl [8];
  int         env_n;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) env_n <= 0;
    else if (sif.stack_push_en && env_n < 8) begin
      env_pc[env_n] <= sif.stack_pc + 9'd1;
      env_fl[env_n] <= sif.stack_flags;
      env_n <= env_n + 1;
    end else if (sif.stack_pop_en && env_n > 0) begin
      env_n <= env_n - 1;
    end
  end

  always_comb begin
    sif.stack_top_pc    = 9'h155;
    sif.stack_top_flags = 4'hA;
    if (env_n > 0) begin
      sif.stack_top_pc    = env_pc[env_n-1];
      sif.stack_top_flags = env_fl[env_n-1];
    end
  end

  // Reference model state
  int   m_pc;
  logic [3:0] m_fl;
  int   m_st;
  bit   m_isr;
  int   m_rpc[$];
  logic [3:0] m_rfl[$];

  int n_chk = 0;
  int n_bad = 0;

  logic       obs_push, obs_pop, obs_ack;
  logic [8:0] obs_spc;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_regs();
    check_eq("pc", int'(pc), m_pc);
    check_eq("flags", int'(flags), int'(m_fl));
    check_eq("depth", int'(depth), m_rpc.size());
    check_eq("in_isr", int'(in_isr), int'(m_isr));
    check_eq("halted", int'(halted), int'(m_st == M_HALT));
    check_eq("fault", int'(fault), int'(m_st == M_FAULT));
  endtask

  // Called at a negedge; returns at the following negedge
  task automatic do_reset();
    en = 0; op = 0; irq = 0; flags_we = 0; cond = 0; target = 0; alu_flags = 0;
    rst_n = 0;
    m_pc = 0; m_fl = 0; m_st = M_RUN; m_isr = 0;
    m_rpc.delete(); m_rfl.delete();
    #1;
    check_regs();
    check_eq("rst_push", int'(sif.stack_push_en), 0);
    check_eq("rst_pop", int'(sif.stack_pop_en), 0);
    check_eq("rst_ack", int'(irq_ack), 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  // One cycle: drive at negedge, check strobes, clock, check registers
  task automatic step(input logic e, input logic [2:0] o, input logic [1:0] c,
                      input logic [8:0] t, input logic [3:0] af,
                      input logic fwe, input logic ir);
    int   d;
    bit   take, e_push, e_pop;
    int   e_spc, n_pc, n_st, popped;
    logic [3:0] n_fl;
    bit   n_isr;
    en = e; op = o; cond = c; target = t; alu_flags = af; flags_we = fwe; irq = ir;
    #1;
    d = m_rpc.size();
    take = ir && !m_isr && d < 5 && m_st != M_FAULT;
    e_push = 0; e_pop = 0; e_spc = m_pc;
    n_pc = m_pc; n_st = m_st; n_isr = m_isr;
    n_fl = (fwe && m_st != M_FAULT) ? af : m_fl;
    if (take) begin
      e_push = 1; e_spc = (m_pc + 511) % 512;
      m_rpc.push_back(m_pc); m_rfl.push_back(m_fl);
      n_pc = VEC; n_isr = 1; n_st = M_RUN;
    end else if (m_st == M_RUN && e) begin
      case (o)
        3'd0: n_pc = (m_pc + 1) % 512;
        3'd1: n_pc = int'(t);
        3'd2: n_pc = m_fl[c] ? int'(t) : (m_pc + 1) % 512;
        3'd3: n_pc = !m_fl[c] ? int'(t) : (m_pc + 1) % 512;
        3'd4: begin
          if (d == 5) n_st = M_FAULT;
          else begin
            e_push = 1;
            m_rpc.push_back((m_pc + 1) % 512); m_rfl.push_back(m_fl);
            n_pc = int'(t);
          end
        end
        3'd5, 3'd7: begin
          if (d == 0) n_st = M_FAULT;
          else begin
            e_pop = 1;
            popped = m_rpc.pop_back();
            n_pc = popped;
            if (o == 3'd7) begin
              n_fl = m_rfl[$];
              n_isr = 0;
            end
            void'(m_rfl.pop_back());
          end
        end
        default: n_st = M_HALT;
      endcase
    end
    obs_push = sif.stack_push_en; obs_pop = sif.stack_pop_en;
    obs_ack = irq_ack; obs_spc = sif.stack_pc;
    check_eq("irq_ack", int'(irq_ack), int'(take));
    check_eq("push_en", int'(obs_push), int'(e_push));
    check_eq("pop_en", int'(obs_pop), int'(e_pop));
    if (e_push) begin
      check_eq("stack_pc", int'(obs_spc), e_spc);
      check_eq("stack_flags", int'(sif.stack_flags), int'(m_fl));
    end
    @(posedge clk);
    m_pc = n_pc; m_fl = n_fl; m_st = n_st; m_isr = n_isr;
    #1;
    check_regs();
    @(negedge clk);
  endtask

  task automatic op1(input logic [2:0] o, input logic [8:0] t);
    step(1'b1, o, 2'd0, t, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    int halt_cnt;
    rst_n = 0; en = 0; op = 0; cond = 0; target = 0;
    alu_flags = 0; flags_we = 0; irq = 0;
    @(negedge clk);
    do_reset();

    // Sequential NEXT
    for (int i = 1; i <= 3; i++) begin
      op1(3'd0, 9'h0);
      check_eq("next_pc", int'(pc), i);
      check_eq("next_nopush", int'(obs_push), 0);
    end

    // CALL / RET round trip
    op1(3'd1, 9'h010);
    op1(3'd4, 9'h080);
    check_eq("call_push", int'(obs_push), 1);
    check_eq("call_spc", int'(obs_spc), 'h010);
    check_eq("call_pc", int'(pc), 'h080);
    check_eq("call_depth", int'(depth), 1);
    op1(3'd5, 9'h0);
    check_eq("ret_pop", int'(obs_pop), 1);
    check_eq("ret_pc", int'(pc), 'h011);
    check_eq("ret_depth", int'(depth), 0);

    // Stack overflow
    for (int i = 0; i < 5; i++) op1(3'd4, 9'(9'h100 + i));
    check_eq("ovf_depth", int'(depth), 5);
    op1(3'd4, 9'h1AA);
    check_eq("ovf_nopush", int'(obs_push), 0);
    check_eq("ovf_fault", int'(fault), 1);
    check_eq("ovf_pc", int'(pc), 'h104);
    op1(3'd1, 9'h0AA);
    check_eq("ovf_frozen", int'(pc), 'h104);
    do_reset();
    check_eq("ovf_cleared", int'(fault), 0);

    // Interrupt discards JMP, RETI restores flags
    step(1'b1, 3'd1, 2'd0, 9'h020, 4'b0101, 1'b1, 1'b0);
    check_eq("isr_flags_set", int'(flags), 5);
    step(1'b1, 3'd1, 2'd0, 9'h100, 4'b0000, 1'b0, 1'b1);
    check_eq("isr_ack", int'(obs_ack), 1);
    check_eq("isr_spc", int'(obs_spc), 'h01F);
    check_eq("isr_pc", int'(pc), 'h1F0);
    check_eq("isr_flag", int'(in_isr), 1);
    step(1'b1, 3'd0, 2'd0, 9'h0, 4'b0000, 1'b1, 1'b1);
    check_eq("isr_held_off", int'(obs_ack), 0);
    check_eq("isr_flags_clr", int'(flags), 0);
    step(1'b1, 3'd7, 2'd0, 9'h0, 4'b1111, 1'b1, 1'b0);
    check_eq("reti_pc", int'(pc), 'h020);
    check_eq("reti_flags", int'(flags), 5);
    check_eq("reti_isr", int'(in_isr), 0);

    // Underflow
    op1(3'd5, 9'h0);
    check_eq("unf_nopop", int'(obs_pop), 0);
    check_eq("unf_fault", int'(fault), 1);
    do_reset();

    // Interrupt at pc 0 wraps return address
    step(1'b0, 3'd0, 2'd0, 9'h0, 4'd0, 1'b0, 1'b1);
    check_eq("wrap_spc", int'(obs_spc), 'h1FF);
    check_eq("wrap_ack", int'(obs_ack), 1);
    do_reset();

    // HALT, wake by interrupt, return re-executes HALT
    op1(3'd1, 9'h030);
    op1(3'd6, 9'h0);
    check_eq("halt_state", int'(halted), 1);
    check_eq("halt_pc", int'(pc), 'h030);
    op1(3'd1, 9'h077);
    check_eq("halt_hold", int'(pc), 'h030);
    step(1'b0, 3'd0, 2'd0, 9'h0, 4'd0, 1'b0, 1'b1);
    check_eq("wake_ack", int'(obs_ack), 1);
    check_eq("wake_pc", int'(pc), 'h1F0);
    check_eq("wake_run", int'(halted), 0);
    op1(3'd7, 9'h0);
    check_eq("wake_ret_pc", int'(pc), 'h030);
    op1(3'd6, 9'h0);
    check_eq("rehalt", int'(halted), 1);

    // Reset while a CALL strobe is in flight
    en = 1; op = 3'd4; target = 9'h0C0; irq = 0; flags_we = 0;
    #4;
    do_reset();
    check_eq("midrst_depth", int'(depth), 0);
    check_eq("midrst_pc", int'(pc), 0);

    // Randomised traffic against the model
    halt_cnt = 0;
    for (int n = 0; n < 1500; n++) begin
      int r;
      logic [2:0] o;
      if (m_st == M_FAULT || halt_cnt > 6) begin
        do_reset();
        halt_cnt = 0;
      end else begin
        r = $urandom_range(0, 15);
        case (r)
          0, 1, 2, 3, 15: o = 3'd0;
          4:              o = 3'd1;
          5:              o = 3'd2;
          6:              o = 3'd3;
          7, 8, 9:        o = 3'd4;
          10, 11, 12:     o = 3'd5;
          13:             o = 3'd7;
          default:        o = ($urandom_range(0, 3) == 0) ? 3'd6 : 3'd0;
        endcase
        step(($urandom_range(0, 7) != 0), o, 2'($urandom_range(0, 3)),
             9'($urandom_range(0, 511)), 4'($urandom_range(0, 15)),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0));
        halt_cnt = (m_st == M_HALT) ? halt_cnt + 1 : 0;
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter and control-flow sequencer directly upstream of the 5-entry return stack.
- Owns the 9-bit PC and the 4-bit flags register.
- Decodes control ops (jump, conditional jump, call, return, halt) and takes single-level interrupts.
- Drives the stack push/pop and PC/flags inputs, and consumes the stack top on return.

Parameters:
- STACK_DEPTH, 5, entries in the downstream stack; the depth counter saturates here.
- IRQ_VECTOR, 9'h1F0, PC loaded when an interrupt is taken.
- RESET_PC, 9'h000, PC after reset.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  op valid this cycle; en=0 holds PC
- op  in  3  000 NEXT, 001 JMP, 010 JIF, 011 JNIF, 100 CALL, 101 RET, 110 HALT, 111 RETI
- cond  in  2  flag index tested by JIF/JNIF
- target  in  9  jump/call destination
- alu_flags  in  4  new flags value
- flags_we  in  1  load alu_flags into flags register
- irq  in  1  level interrupt request
- irq_ack  out  1  one-cycle pulse, interrupt taken
- pc  out  9  current PC (registered)
- flags  out  4  current flags (registered)
- stack_push_en  out  1  to stack push_en
- stack_pop_en  out  1  to stack pop_en
- stack_pc  out  9  to stack in_pc; the stack stores this value +1
- stack_flags  out  4  to stack in_flags
- stack_top_pc  in  9  from stack out_pc
- stack_top_flags  in  4  from stack out_flags
- depth  out  3  entries currently held by the stack, 0..STACK_DEPTH
- in_isr  out  1  interrupt service active
- halted  out  1  state==HALT
- fault  out  1  state==FAULT (sticky)

Behaviour:
- Reset values: pc=RESET_PC, flags=0, depth=0, in_isr=0, state=RUN, all strobes 0.
- States:
  - RUN: executes ops.
  - HALT: entered by HALT op. PC held, ops ignored. Leaves only on a taken irq, which moves to RUN.
  - FAULT: PC held, no strobes. Leaves only on reset.
- Stack strobes are combinational from the current state and inputs, valid in the cycle the op is presented. The stack updates on the same edge that updates pc. Push and pop are never asserted together.
- PC updates, all mod 512, 1-cycle latency:
  - NEXT: pc+1.
  - JMP: target.
  - JIF: target if flags[cond]==1, else pc+1.
  - JNIF: target if flags[cond]==0, else pc+1.
- CALL:
  - push_en=1, stack_pc=pc, stack_flags=flags (value before any same-cycle flags_we).
  - pc<=target, depth+1.
  - At depth==STACK_DEPTH: no push, state<=FAULT.
- RET: pop_en=1, pc<=stack_top_pc, depth-1, flags unchanged.
- RETI: same as RET, plus flags<=stack_top_flags and in_isr<=0.
- RET/RETI at depth==0: no pop, state<=FAULT.
- Interrupt taken when irq=1, in_isr=0, depth<STACK_DEPTH and state is RUN or HALT. It is evaluated before op and the op is discarded.
  - push_en=1, stack_pc=pc-1 (wraps 0 to 511), so the return lands on the un-executed pc.
  - pc<=IRQ_VECTOR, in_isr<=1, depth+1, irq_ack=1 for that cycle, state<=RUN.
  - en is not required for an interrupt to be taken.
- irq is held off (no ack) while in_isr=1 or depth==STACK_DEPTH.
- flags_we: flags<=alu_flags unless the same cycle is RETI, in which case RETI wins. Ignored in FAULT.
- en=0 with no interrupt: nothing changes except flags_we.
- Reset mid-operation: async clear of all state; a strobe in flight is dropped.

Decomposition:
- Shared package holds:
  - op encodings (OP_NEXT..OP_RETI);
  - state encodings RUN/HALT/FAULT;
  - flag bit indices Z=0, C=1, N=2, V=3;
  - PC_W=9 and FLAGS_W=4.
- One sub-module, pc_next_logic: combinational next-PC and strobe decode. The top module holds the registers and FSM.

Test Plan:
- Reset, then 3× NEXT -> pc 0,1,2,3; flags=0; no strobes.
- pc=0x010, CALL target=0x080, then RET -> push with stack_pc=0x010; pc=0x080, depth=1. RET pops, pc=0x011, depth=0.
- 5 nested CALLs then a 6th CALL -> depth=5, 6th has no push_en, fault=1, pc frozen. Reset clears it.
- pc=0x020, flags=4'b0101, irq=1 with op=JMP 0x100 -> JMP discarded, irq_ack pulse, stack_pc=0x01F, pc=0x1F0, in_isr=1. flags_we 4'b0000, then RETI -> pc=0x020, flags=4'b0101, in_isr=0.
- RET at depth=0 -> no pop_en, fault=1. Separately, pc=0, irq -> stack_pc=0x1FF.
- HALT at pc=0x030 -> halted=1, pc stays 0x030. irq -> ack, pc=0x1F0, RUN. RETI -> pc=0x030, which re-executes HALT.
